alu_op_sequencer: RTL

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer_pkg.sv | 75 +++++++
 rtl/alu_op_sequencer_reg_decode.sv | 21 ++
 rtl/alu_op_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: op codes, FSM states,
// bus source indices and the width constants used across the block.
package alu_op_sequencer_pkg;

   localparam int IDX_W = 4;
   localparam int REG_N = 16;
   localparam int BUS_W = 24;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_SHR = 4'd4;
   localparam logic [3:0] OP_SHL = 4'd5;
   localparam logic [3:0] OP_ROR = 4'd6;
   localparam logic [3:0] OP_ROL = 4'd7;
   localparam logic [3:0] OP_NEG = 4'd8;
   localparam logic [3:0] OP_NOT = 4'd9;
   localparam logic [3:0] OP_MUL = 4'd10;
   localparam logic [3:0] OP_DIV = 4'd11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_T1   = 3'd1,
      ST_T2   = 3'd2,
      ST_T3   = 3'd3,
      ST_T4   = 3'd4,
      ST_ERR  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      CLS_BIN  = 2'd0,
      CLS_UN   = 2'd1,
      CLS_WIDE = 2'd2,
      CLS_ILL  = 2'd3
   } op_class_t;

   localparam logic [4:0] SRC_R0     = 5'd0;
   localparam logic [4:0] SRC_R1     = 5'd1;
   localparam logic [4:0] SRC_R2     = 5'd2;
   localparam logic [4:0] SRC_R3     = 5'd3;
   localparam logic [4:0] SRC_R4     = 5'd4;
   localparam logic [4:0] SRC_R5     = 5'd5;
   localparam logic [4:0] SRC_R6     = 5'd6;
   localparam logic [4:0] SRC_R7     = 5'd7;
   localparam logic [4:0] SRC_R8     = 5'd8;
   localparam logic [4:0] SRC_R9     = 5'd9;
   localparam logic [4:0] SRC_R10    = 5'd10;
   localparam logic [4:0] SRC_R11    = 5'd11;
   localparam logic [4:0] SRC_R12    = 5'd12;
   localparam logic [4:0] SRC_R13    = 5'd13;
   localparam logic [4:0] SRC_R14    = 5'd14;
   localparam logic [4:0] SRC_R15    = 5'd15;
   localparam logic [4:0] SRC_HI     = 5'd16;
   localparam logic [4:0] SRC_LO     = 5'd17;
   localparam logic [4:0] SRC_ZHI    = 5'd18;
   localparam logic [4:0] SRC_ZLO    = 5'd19;
   localparam logic [4:0] SRC_PC     = 5'd20;
   localparam logic [4:0] SRC_MDR    = 5'd21;
   localparam logic [4:0] SRC_INPORT = 5'd22;
   localparam logic [4:0] SRC_C      = 5'd23;

   function automatic op_class_t op_class(input logic [3:0] op);
      op_class_t cls;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = CLS_BIN;
         OP_NEG, OP_NOT:                 cls = CLS_UN;
         OP_MUL, OP_DIV:                 cls = CLS_WIDE;
         default:                        cls = CLS_ILL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/alu_op_sequencer_reg_decode.sv
// Gated 4-to-16 one-hot decoder used for the register source and destination
// enables; a deasserted enable yields an all-zero vector.
module reg_decode_4to16
   import alu_op_sequencer_pkg::*;
(
   input  logic [IDX_W-1:0] i_idx,
   input  logic             i_en,
   output logic [REG_N-1:0] o_onehot
);

   // One-hot decode of the index, suppressed when not enabled
   always_comb begin
      o_onehot = {REG_N{1'b0}};
      if (i_en) begin
         o_onehot[i_idx] = 1'b1;
      end else begin
         o_onehot = {REG_N{1'b0}};
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Micro-step sequencer driving bus source, register load and ALU controls
// for binary, unary and wide (MUL/DIV) operations.
module alu_op_sequencer
   import alu_op_sequencer_pkg::*;
(
   input  logic             clock,
   input  logic             clear,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_op,
   input  logic [IDX_W-1:0] req_ra,
   input  logic [IDX_W-1:0] req_rb,
   input  logic [IDX_W-1:0] req_rd,
   output logic [BUS_W-1:0] src_out,
   output logic [REG_N-1:0] r_in,
   output logic             y_in,
   output logic             z_in,
   output logic             hi_in,
   output logic             lo_in,
   output logic [3:0]       alu_op,
   output logic             done,
   output logic             err
);

   state_t           r_state;
   state_t           w_next_state;
   logic [3:0]       r_op;
   logic [IDX_W-1:0] r_ra;
   logic [IDX_W-1:0] r_rb;
   logic [IDX_W-1:0] r_rd;

   logic             w_accept;
   op_class_t        w_cls_req;
   op_class_t        w_cls_n;
   logic [3:0]       w_op_n;
   logic [IDX_W-1:0] w_ra_n;
   logic [IDX_W-1:0] w_rb_n;
   logic [IDX_W-1:0] w_rd_n;

   logic [IDX_W-1:0] w_src_idx;
   logic             w_src_en;
   logic [BUS_W-1:0] w_src_spec;
   logic [REG_N-1:0] w_src_dec;
   logic             w_dst_en;
   logic [REG_N-1:0] w_rin_n;
   logic [BUS_W-1:0] w_src_out_n;
   logic             w_y_n;
   logic             w_z_n;
   logic             w_hi_n;
   logic             w_lo_n;
   logic [3:0]       w_alu_n;
   logic             w_done_n;
   logic             w_err_n;

   logic             r_req_ready;
   logic [BUS_W-1:0] r_src_out;
   logic [REG_N-1:0] r_rin;
   logic             r_y_in;
   logic             r_z_in;
   logic             r_hi_in;
   logic             r_lo_in;
   logic [3:0]       r_alu_op;
   logic             r_done;
   logic             r_err;

   // Outputs are registered; the decode below targets the state being entered
   assign w_accept  = (r_state == ST_IDLE) && req_valid;
   assign w_cls_req = op_class(req_op);
   assign w_op_n    = w_accept ? req_op : r_op;
   assign w_ra_n    = w_accept ? req_ra : r_ra;
   assign w_rb_n    = w_accept ? req_rb : r_rb;
   assign w_rd_n    = w_accept ? req_rd : r_rd;
   assign w_cls_n   = op_class(w_op_n);

   // Next-state selection
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               case (w_cls_req)
                  CLS_BIN:  w_next_state = ST_T1;
                  CLS_WIDE: w_next_state = ST_T1;
                  CLS_UN:   w_next_state = ST_T2;
                  default:  w_next_state = ST_ERR;
               endcase
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_T1:   w_next_state = ST_T2;
         ST_T2:   w_next_state = ST_T3;
         ST_T3: begin
            if (w_cls_n == CLS_WIDE) begin
               w_next_state = ST_T4;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_T4:   w_next_state = ST_IDLE;
         ST_ERR:  w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Control decode for the upcoming state
   always_comb begin
      w_src_idx  = {IDX_W{1'b0}};
      w_src_en   = 1'b0;
      w_src_spec = {BUS_W{1'b0}};
      w_dst_en   = 1'b0;
      w_y_n      = 1'b0;
      w_z_n      = 1'b0;
      w_hi_n     = 1'b0;
      w_lo_n     = 1'b0;
      w_alu_n    = 4'd0;
      w_done_n   = 1'b0;
      w_err_n    = 1'b0;
      case (w_next_state)
         ST_T1: begin
            w_src_idx = w_ra_n;
            w_src_en  = 1'b1;
            w_y_n     = 1'b1;
         end
         ST_T2: begin
            if (w_cls_n == CLS_UN) begin
               w_src_idx = w_ra_n;
            end else begin
               w_src_idx = w_rb_n;
            end
            w_src_en = 1'b1;
            w_z_n    = 1'b1;
            w_alu_n  = w_op_n;
         end
         ST_T3: begin
            w_src_spec[SRC_ZLO] = 1'b1;
            if (w_cls_n == CLS_WIDE) begin
               w_lo_n = 1'b1;
            end else begin
               w_dst_en = 1'b1;
               w_done_n = 1'b1;
            end
         end
         ST_T4: begin
            w_src_spec[SRC_ZHI] = 1'b1;
            w_hi_n              = 1'b1;
            w_done_n            = 1'b1;
         end
         ST_ERR: begin
            w_err_n  = 1'b1;
            w_done_n = 1'b1;
         end
         default: begin
            w_src_en = 1'b0;
         end
      endcase
   end

   reg_decode_4to16 u_src_dec (
      .i_idx    (w_src_idx),
      .i_en     (w_src_en),
      .o_onehot (w_src_dec)
   );

   reg_decode_4to16 u_dst_dec (
      .i_idx    (w_rd_n),
      .i_en     (w_dst_en),
      .o_onehot (w_rin_n)
   );

   assign w_src_out_n = {{(BUS_W-REG_N){1'b0}}, w_src_dec} | w_src_spec;

   // State, captured fields and registered outputs; clear wins over everything
   always_ff @(posedge clock) begin
      if (clear) begin
         r_state     <= ST_IDLE;
         r_op        <= 4'd0;
         r_ra        <= {IDX_W{1'b0}};
         r_rb        <= {IDX_W{1'b0}};
         r_rd        <= {IDX_W{1'b0}};
         r_req_ready <= 1'b1;
         r_src_out   <= {BUS_W{1'b0}};
         r_rin       <= {REG_N{1'b0}};
         r_y_in      <= 1'b0;
         r_z_in      <= 1'b0;
         r_hi_in     <= 1'b0;
         r_lo_in     <= 1'b0;
         r_alu_op    <= 4'd0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_op        <= w_op_n;
         r_ra        <= w_ra_n;
         r_rb        <= w_rb_n;
         r_rd        <= w_rd_n;
         r_req_ready <= (w_next_state == ST_IDLE);
         r_src_out   <= w_src_out_n;
         r_rin       <= w_rin_n;
         r_y_in      <= w_y_n;
         r_z_in      <= w_z_n;
         r_hi_in     <= w_hi_n;
         r_lo_in     <= w_lo_n;
         r_alu_op    <= w_alu_n;
         r_done      <= w_done_n;
         r_err       <= w_err_n;
      end
   end

   assign req_ready = r_req_ready;
   assign src_out   = r_src_out;
   assign r_in      = r_rin;
   assign y_in      = r_y_in;
   assign z_in      = r_z_in;
   assign hi_in     = r_hi_in;
   assign lo_in     = r_lo_in;
   assign alu_op    = r_alu_op;
   assign done      = r_done;
   assign err       = r_err;

endmodule
